ripple_adder_4bit: RTL and testbench

Registered 4-bit unsigned ripple-carry adder. Adds two 4-bit operands through a chain of single-bit full adders and registers the 5-bit result, with the carry-out as the MSB. It is a leaf datapath block used wherever a small add with a one-cycle registered result is needed.

---
 rtl/ripple_adder_pkg.sv | 8 +
 rtl/ripple_adder_4bit_full_adder.sv | 16 +
 rtl/ripple_adder_4bit.sv | 60 ++++++
 tb/tb_ripple_adder_4bit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ripple_adder_pkg.sv
// Shared width and result type for the registered ripple adder.
package ripple_adder_pkg;

  localparam int RA_WIDTH = 4;

  typedef logic [RA_WIDTH:0] ra_sum_t;

endpackage

// File: rtl/ripple_adder_4bit_full_adder.sv
// Single-bit full adder cell used to build the ripple carry chain.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);

endmodule

// File: rtl/ripple_adder_4bit.sv
// Registered unsigned ripple-carry adder, carry-out kept as result MSB.
// Define RIPPLE_ADDER_CIN_EN to add a cin port feeding stage 0.
module ripple_adder_4bit
  import ripple_adder_pkg::*;
#(
  parameter int WIDTH = RA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef RIPPLE_ADDER_CIN_EN
  input  logic             cin,
`endif
  output logic [WIDTH:0]   sum,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s_w;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   sum_q;
  logic             vld_d;
  logic             vld_q;

`ifdef RIPPLE_ADDER_CIN_EN
  assign carry[0] = cin;
`else
  assign carry[0] = 1'b0;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .x  (a[i]),
      .y  (b[i]),
      .ci (carry[i]),
      .s  (s_w[i]),
      .co (carry[i+1])
    );
  end

  assign sum_d = {carry[WIDTH], s_w};
  assign vld_d = in_valid;

  // Result holds when idle; valid only marks a fresh capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (in_valid) sum_q <= sum_d;
    end
  end

  assign sum       = sum_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_ripple_adder_4bit.sv
// Directed self-checking bench for ripple_adder_4bit.
module tb_ripple_adder_4bit;
  import ripple_adder_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
`ifdef RIPPLE_ADDER_CIN_EN
  logic       cin;
`endif
  ra_sum_t    sum;
  logic       out_valid;

  int total;
  int bad;

  ripple_adder_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
`ifdef RIPPLE_ADDER_CIN_EN
    .cin       (cin),
`endif
    .sum       (sum),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic v,
                       input logic [3:0] xa,
                       input logic [3:0] xb);
    rst      = r;
    in_valid = v;
    a        = xa;
    b        = xb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b1, 4'hF, 4'hF);
    drive(1'b1, 1'b1, 4'hF, 4'hF);
    total++;
    if (sum !== 5'd0) begin
      bad++;
      $display("FAIL reset_sum got=%0d want=0", sum);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_vld got=%b want=0", out_valid);
    end
  endtask

  task automatic test_zero_mid;
    logic [3:0] va [3];
    logic [3:0] vb [3];
    ra_sum_t    ve [3];
    va = '{4'd0, 4'd6,  4'd2};
    vb = '{4'd0, 4'd10, 4'd4};
    ve = '{5'b00000, 5'b10000, 5'b00110};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, va[i], vb[i]);
      total++;
      if (sum !== ve[i] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL mid%0d got=%0d/%b want=%0d/1",
                 i, sum, out_valid, ve[i]);
      end
    end
  endtask

  task automatic test_carry;
    logic [3:0] va [3];
    logic [3:0] vb [3];
    ra_sum_t    ve [3];
    va = '{4'd15, 4'd15, 4'd7};
    vb = '{4'd15, 4'd1,  4'd14};
    ve = '{5'b11110, 5'b10000, 5'b10101};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, va[i], vb[i]);
      total++;
      if (sum !== ve[i] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL carry%0d got=%0d/%b want=%0d/1",
                 i, sum, out_valid, ve[i]);
      end
    end
  endtask

  task automatic test_hold;
    drive(1'b0, 1'b0, 4'd3, 4'd9);
    total++;
    if (sum !== 5'd21 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold0 got=%0d/%b want=21/0",
               sum, out_valid);
    end
    drive(1'b0, 1'b0, 4'd12, 4'd5);
    total++;
    if (sum !== 5'd21 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold1 got=%0d/%b want=21/0",
               sum, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b0, 1'b1, 4'd6, 4'd10);
    total++;
    if (sum !== 5'd16 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rm_pre got=%0d/%b want=16/1",
               sum, out_valid);
    end
    drive(1'b1, 1'b1, 4'd15, 4'd15);
    total++;
    if (sum !== 5'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rm_rst got=%0d/%b want=0/0",
               sum, out_valid);
    end
    drive(1'b0, 1'b1, 4'd2, 4'd4);
    total++;
    if (sum !== 5'd6 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rm_post got=%0d/%b want=6/1",
               sum, out_valid);
    end
  endtask

`ifdef RIPPLE_ADDER_CIN_EN
  task automatic test_cin;
    ra_sum_t exp;
    cin = 1'b1;
    drive(1'b0, 1'b1, 4'd15, 4'd15);
    total++;
    if (sum !== 5'd31) begin
      bad++;
      $display("FAIL cin_max got=%0d want=31", sum);
    end
    drive(1'b0, 1'b1, 4'd0, 4'd0);
    total++;
    if (sum !== 5'd1) begin
      bad++;
      $display("FAIL cin_zero got=%0d want=1", sum);
    end
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 256; i++) begin
        cin = c[0];
        exp = 5'(i % 16) + 5'(i / 16) + 5'(c);
        drive(1'b0, 1'b1, 4'(i % 16), 4'(i / 16));
        total++;
        if (sum !== exp || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL sweep a=%0d b=%0d c=%0d got=%0d want=%0d",
                   i % 16, i / 16, c, sum, exp);
        end
      end
    end
    cin = 1'b0;
  endtask
`endif

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
`ifdef RIPPLE_ADDER_CIN_EN
    cin      = 1'b0;
`endif
    test_reset;
    test_zero_mid;
    test_carry;
    test_hold;
    test_reset_mid;
`ifdef RIPPLE_ADDER_CIN_EN
    test_cin;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
